// File: rtl/modulo_controller_if.sv
// rtl/modulo_controller_if.sv - request/datapath handshake bundle for the modulo controller
interface modulo_controller_if;
    logic        start_i;
    logic [15:0] divisor_i;
    logic        term_i;
    logic [2:0]  alu_mode_o;
    logic        wren_update_zahlen_o;
    logic        wren_zahl1_to_erg_o;
    logic        wren_term_erg_o;
    logic        wren_res_to_erg_o;
    logic        erg_to_alu_a_o;
    logic        zahl2_to_alu_b_o;
    logic        check_for_termination_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    modport master (
        output start_i, divisor_i, term_i,
        input  alu_mode_o, wren_update_zahlen_o, wren_zahl1_to_erg_o, wren_term_erg_o,
               wren_res_to_erg_o, erg_to_alu_a_o, zahl2_to_alu_b_o,
               check_for_termination_o, busy_o, done_o, err_o
    );

    modport slave (
        input  start_i, divisor_i, term_i,
        output alu_mode_o, wren_update_zahlen_o, wren_zahl1_to_erg_o, wren_term_erg_o,
               wren_res_to_erg_o, erg_to_alu_a_o, zahl2_to_alu_b_o,
               check_for_termination_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/modulo_controller.sv
// rtl/modulo_controller.sv - repeated-subtraction modulo sequencer; MODULO_CTRL_TIMEOUT_EN adds an iteration limit
module modulo_controller #(
    parameter logic [2:0]  MODE_SUB = 3'd1,
    parameter logic [2:0]  MODE_LT  = 3'd2,
    parameter logic [15:0] MAX_ITER = 16'd1024
) (
    input  logic               clk,
    input  logic               rst,
    modulo_controller_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE, WAIT_IN, LOAD, INIT, CMP_A, CMP_B, CMP_WB, CHECK, SUB_A, SUB_B, SUB_WB, DONE
    } state_t;

    typedef struct packed {
        logic [2:0] alu_mode;
        logic       wr_upd;
        logic       wr_z1;
        logic       wr_term;
        logic       wr_res;
        logic       erg_a;
        logic       z2_b;
        logic       chk;
        logic       busy;
        logic       done;
    } ctrl_t;

    state_t state;
    ctrl_t  ctrl;
    logic   err_q;

    // Moore decode of a state; registered together with the state so outputs are glitch-free.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c      = '0;
        c.busy = (s != IDLE) && (s != DONE);
        case (s)
            LOAD:   c.wr_upd = 1'b1;
            INIT:   c.wr_z1  = 1'b1;
            CMP_A, CMP_B, CMP_WB: begin
                c.alu_mode = MODE_LT;
                c.erg_a    = 1'b1;
                c.z2_b     = 1'b1;
                c.wr_term  = (s == CMP_WB);
            end
            CHECK:  c.chk = 1'b1;
            SUB_A, SUB_B, SUB_WB: begin
                c.alu_mode = MODE_SUB;
                c.erg_a    = 1'b1;
                c.z2_b     = 1'b1;
                c.wr_res   = (s == SUB_WB);
            end
            DONE:   c.done = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    task automatic goto(input state_t s);
        state <= s;
        ctrl  <= decode(s);
    endtask

`ifdef MODULO_CTRL_TIMEOUT_EN
    logic [15:0] iter_cnt;
`else
    logic unused_max_iter;
    assign unused_max_iter = ^MAX_ITER;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ctrl  <= '0;
            err_q <= 1'b0;
`ifdef MODULO_CTRL_TIMEOUT_EN
            iter_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        if (bus.divisor_i == 16'd0) begin
                            goto(DONE);
                            err_q <= 1'b1;
                        end else begin
                            goto(WAIT_IN);
                        end
                    end
                end
                WAIT_IN: goto(LOAD);
                LOAD:    goto(INIT);
                INIT: begin
                    goto(CMP_A);
`ifdef MODULO_CTRL_TIMEOUT_EN
                    iter_cnt <= '0;
`endif
                end
                CMP_A:   goto(CMP_B);
                CMP_B:   goto(CMP_WB);
                CMP_WB:  goto(CHECK);
                CHECK: begin
                    if (bus.term_i) begin
                        goto(DONE);
`ifdef MODULO_CTRL_TIMEOUT_EN
                    end else if (iter_cnt == MAX_ITER) begin
                        goto(DONE);
                        err_q <= 1'b1;
`endif
                    end else begin
                        goto(SUB_A);
                    end
                end
                SUB_A:   goto(SUB_B);
                SUB_B:   goto(SUB_WB);
                SUB_WB: begin
                    goto(CMP_A);
`ifdef MODULO_CTRL_TIMEOUT_EN
                    iter_cnt <= iter_cnt + 16'd1;
`endif
                end
                DONE: begin
                    goto(IDLE);
                    err_q <= 1'b0;
                end
                default: goto(IDLE);
            endcase
        end
    end

    assign bus.alu_mode_o              = ctrl.alu_mode;
    assign bus.wren_update_zahlen_o    = ctrl.wr_upd;
    assign bus.wren_zahl1_to_erg_o     = ctrl.wr_z1;
    assign bus.wren_term_erg_o         = ctrl.wr_term;
    assign bus.wren_res_to_erg_o       = ctrl.wr_res;
    assign bus.erg_to_alu_a_o          = ctrl.erg_a;
    assign bus.zahl2_to_alu_b_o        = ctrl.z2_b;
    assign bus.check_for_termination_o = ctrl.chk;
    assign bus.busy_o                  = ctrl.busy;
    assign bus.done_o                  = ctrl.done;
    // err only ever holds while sitting in DONE, so it doubles as the qualified output.
    assign bus.err_o                   = err_q;

endmodule

// File: tb/tb_modulo_controller.sv
// tb/tb_modulo_controller.sv - directed bench for modulo_controller with a behavioural datapath
module tb_modulo_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    modulo_controller_if bus();

`ifdef MODULO_CTRL_TIMEOUT_EN
    modulo_controller #(.MAX_ITER(16'd2)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
    modulo_controller dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    // Datapath: Zahl1/Zahl2 input registers, ergebnis accumulator, termination flag.
    logic [15:0] zahl1_in;
    logic [15:0] z1_reg, z2_reg, erg, alu_a, alu_b, alu_y;
    logic        dp_valid;

    assign alu_a = bus.erg_to_alu_a_o   ? erg    : z1_reg;
    assign alu_b = bus.zahl2_to_alu_b_o ? z2_reg : 16'd0;
    assign alu_y = (bus.alu_mode_o == 3'd1) ? alu_a - alu_b :
                   (bus.alu_mode_o == 3'd2) ? {15'd0, alu_a < alu_b} : 16'd0;
    assign bus.term_i = dp_valid;

    always @(posedge clk) begin
        if (rst) begin
            z1_reg <= '0; z2_reg <= '0; erg <= '0; dp_valid <= 1'b0;
        end else begin
            if (bus.wren_update_zahlen_o) begin
                z1_reg <= zahl1_in;
                z2_reg <= bus.divisor_i;
            end
            if (bus.wren_zahl1_to_erg_o) erg      <= z1_reg;
            if (bus.wren_term_erg_o)     dp_valid <= alu_y[0];
            if (bus.wren_res_to_erg_o)   erg      <= alu_y;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    function automatic logic [12:0] all_outs();
        return {bus.alu_mode_o, bus.wren_update_zahlen_o, bus.wren_zahl1_to_erg_o,
                bus.wren_term_erg_o, bus.wren_res_to_erg_o, bus.erg_to_alu_a_o,
                bus.zahl2_to_alu_b_o, bus.check_for_termination_o, bus.busy_o,
                bus.done_o, bus.err_o};
    endfunction

    int   res_cycle, res_subs, res_wrens, res_dones, onehot_viol;
    logic res_err;

    // Accept happens in cycle 0; cycle numbers count negedges after the accepting edge.
    task automatic run(input logic [15:0] z1, input logic [15:0] dv, input bit hold);
        int wr;
        @(negedge clk);
        zahl1_in = z1; bus.divisor_i = dv; bus.start_i = 1'b1;
        res_cycle = -1; res_err = 1'b0; res_subs = 0; res_wrens = 0; res_dones = 0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (!hold) bus.start_i = 1'b0;
            wr = int'(bus.wren_update_zahlen_o) + int'(bus.wren_zahl1_to_erg_o) +
                 int'(bus.wren_term_erg_o) + int'(bus.wren_res_to_erg_o);
            res_wrens += wr;
            if (wr > 1) onehot_viol++;
            if (bus.wren_res_to_erg_o) res_subs++;
            if (bus.done_o) begin
                res_dones++;
                res_cycle = c;
                res_err   = bus.err_o;
                break;
            end
        end
    endtask

    initial begin
        bus.start_i = 1'b0; bus.divisor_i = '0; zahl1_in = '0; onehot_viol = 0;
        repeat (3) @(negedge clk);
        check("reset_outs", 32'(all_outs()), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outs", 32'(all_outs()), 32'd0);

        run(16'd7, 16'd3, 1'b0);
        check("7mod3_cycle", res_cycle, 22);
        check("7mod3_err", 32'(res_err), 0);
        check("7mod3_erg", 32'(erg), 1);
        check("7mod3_subs", res_subs, 2);

        run(16'd5, 16'd7, 1'b0);
        check("5mod7_cycle", res_cycle, 8);
        check("5mod7_subs", res_subs, 0);
        check("5mod7_erg", 32'(erg), 5);

        run(16'd9, 16'd0, 1'b0);
        check("div0_cycle", res_cycle, 1);
        check("div0_err", 32'(res_err), 1);
        check("div0_wrens", res_wrens, 0);
        @(negedge clk);
        check("div0_err_cleared", 32'(all_outs()), 32'd0);

        // Reset in SUB_B of 9 mod 2: SUB_A is cycle 8, SUB_B cycle 9.
        zahl1_in = 16'd9; bus.divisor_i = 16'd2; bus.start_i = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
        end
        check("sub_b_mode", 32'(bus.alu_mode_o), 1);
        check("sub_b_no_wren", 32'(bus.wren_res_to_erg_o), 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_outs", 32'(all_outs()), 32'd0);
        rst = 1'b0;
        run(16'd9, 16'd2, 1'b0);
        check("9mod2_cycle", res_cycle, 36);
        check("9mod2_erg", 32'(erg), 1);

        // start held high throughout: one done, re-accept right after DONE.
        run(16'd6, 16'd3, 1'b1);
        check("hold_cycle", res_cycle, 22);
        check("hold_erg", 32'(erg), 0);
        check("hold_dones", res_dones, 1);
        @(negedge clk);
        check("hold_idle_busy", 32'(bus.busy_o), 0);
        check("hold_idle_done", 32'(bus.done_o), 0);
        @(negedge clk);
        check("hold_reaccept_busy", 32'(bus.busy_o), 1);
        bus.start_i = 1'b0;
        begin
            int c;
            c = 0;
            while (!bus.done_o && c < 400) begin
                @(negedge clk);
                c++;
            end
            check("hold_second_done", 32'(bus.done_o), 1);
        end

`ifdef MODULO_CTRL_TIMEOUT_EN
        run(16'd100, 16'd1, 1'b0);
        check("timeout_cycle", res_cycle, 22);
        check("timeout_err", 32'(res_err), 1);
        check("timeout_subs", res_subs, 2);
`endif

        check("onehot_wren", onehot_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/modulo_controller.md
MODULO_CONTROLLER -- requirements
Module: modulo_controller

Interface
REQ-001 Parameter MODE_SUB, default 3'd1, alu_mode_i code for op_a - op_b.
REQ-002 Parameter MODE_LT, default 3'd2, alu_mode_i code for (op_a < op_b) ? 1 : 0.
REQ-003 Parameter MAX_ITER, default 16'd1024, subtraction-iteration limit (used only with REQ-030).
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start_i  in  1  request pulse; accepted only in IDLE.
REQ-007 divisor_i  in  16  divisor, same bus as datapath Zahl2_i; sampled on accept.
REQ-008 term_i  in  1  datapath valid_o, the termination flag.
REQ-009 alu_mode_o  out  3  ALU operation select.
REQ-010 wren_update_zahlen_o, wren_zahl1_to_erg_o, wren_term_erg_o, wren_res_to_erg_o  out  1 each  datapath write-back strobes.
REQ-011 erg_to_alu_a_o, zahl2_to_alu_b_o  out  1 each  operand routing.
REQ-012 check_for_termination_o  out  1  termination qualify to datapath.
REQ-013 busy_o  out  1  operation in progress; done_o  out  1  one-cycle completion pulse; err_o  out  1  error qualifier, valid with done_o.

Function
REQ-014 States: IDLE, WAIT_IN, LOAD, INIT, CMP_A, CMP_B, CMP_WB, CHECK, SUB_A, SUB_B, SUB_WB, DONE; one state per cycle; Moore outputs.
REQ-015 IDLE: start_i=1 with divisor_i!=0 -> WAIT_IN; with divisor_i==0 -> DONE with err latched; else stay.
REQ-016 WAIT_IN: no strobes (datapath input registers settle) -> LOAD.
REQ-017 LOAD: wren_update_zahlen_o=1 -> INIT.
REQ-018 INIT: wren_zahl1_to_erg_o=1; iteration counter cleared -> CMP_A.
REQ-019 CMP_A, CMP_B, CMP_WB: alu_mode_o=MODE_LT, erg_to_alu_a_o=1, zahl2_to_alu_b_o=1; CMP_WB additionally wren_term_erg_o=1; chain CMP_A->CMP_B->CMP_WB->CHECK.
REQ-020 CHECK: check_for_termination_o=1; term_i=1 -> DONE; else -> SUB_A.
REQ-021 SUB_A, SUB_B, SUB_WB: alu_mode_o=MODE_SUB, both routing strobes=1; SUB_WB additionally wren_res_to_erg_o=1, iteration counter +1; chain -> CMP_A.
REQ-022 DONE: done_o=1, err_o=latched err, busy_o=0 -> IDLE; err cleared on leaving DONE.
REQ-023 busy_o=1 in every state except IDLE and DONE.
REQ-024 Outputs not listed for a state SHALL be 0 there; alu_mode_o=3'd0 outside compare/subtract states.
REQ-025 At most one wren_* strobe SHALL be high per cycle.
REQ-026 Latency: accept at cycle 0, quotient q -> done_o in cycle 8+7q; divisor 0 -> done_o+err_o in cycle 1.
REQ-027 start_i outside IDLE (including DONE) SHALL be ignored, no queuing.
REQ-028 Operand range 0..16'h7FFF (signed ALU); requester SHALL hold operands stable from accept to done_o; behaviour outside is unspecified.

Reset
REQ-029 rst=1 SHALL force IDLE on the next edge from any state, clear counter and err; all outputs 0 during and after reset until a new accept.

Configuration
REQ-030 Macro MODULO_CTRL_TIMEOUT_EN: defined -> 16-bit iteration counter compiled in; in CHECK with term_i=0 and counter==MAX_ITER -> DONE with err_o=1. Undefined -> counter absent, err_o only from zero divisor, loop unbounded.

Verification
REQ-031 Zahl1=7, divisor=3, accept cycle 0 -> done_o cycle 22, err_o=0, ergebnis=1, two SUB_WB strobes.
REQ-032 Zahl1=5, divisor=7 -> done_o cycle 8, no SUB states visited, ergebnis=5.
REQ-033 divisor=0 -> done_o=1, err_o=1 in cycle 1, no wren_* strobe ever asserted.
REQ-034 rst asserted in SUB_B of a 9 mod 2 run -> IDLE next cycle, all outputs 0; fresh 9 mod 2 -> ergebnis=1, done_o cycle 36.
REQ-035 start_i held high throughout a 6 mod 3 run -> exactly one done_o (cycle 22), next accept in the cycle after DONE.
REQ-036 With MODULO_CTRL_TIMEOUT_EN, MAX_ITER=2, Zahl1=100, divisor=1 -> done_o with err_o=1 after second SUB_WB, cycle 22.
